// File: rtl/double_loop_gen_pkg.sv
// Shared sizing for the nested-loop address generator.
// Default address/count width and the matching address type.
// No flow control; constants and types only.
package double_loop_gen_pkg;
    localparam int DL_AW = 6;
    typedef logic [DL_AW-1:0] dl_addr_t;
endpackage

// File: rtl/loop_pipe_delay.sv
// Generic register chain with synchronous reset; STAGES=0 is a pass-through.
// Latency: STAGES cycles.
// No backpressure; data advances every cycle.
module loop_pipe_delay #(
    parameter int STAGES = 0,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);
    generate
        if (STAGES == 0) begin : g_pass
            logic w_unused;
            assign w_unused = &{1'b0, clk, reset};
            assign o_dat    = i_dat;
        end else begin : g_chain
            logic [WIDTH-1:0] r_pipe [STAGES];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < STAGES; k++) r_pipe[k] <= '0;
                end else begin
                    r_pipe[0] <= i_dat;
                    for (int k = 1; k < STAGES; k++) r_pipe[k] <= r_pipe[k-1];
                end
            end
            assign o_dat = r_pipe[STAGES-1];
        end
    endgenerate
endmodule

// File: rtl/double_loop_gen.sv
// Nested-loop (i,j) pair generator, row-major, one pair per clock; optional `done` via DOUBLE_LOOP_DONE_EN.
// Latency: first pair 1 + OUT_STAGES cycles after the reset edge.
// No backpressure; reset doubles as the restart strobe and abandons any run.
module double_loop_gen
    import double_loop_gen_pkg::*;
#(
    parameter int AW         = DL_AW,
    parameter int OUT_STAGES = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] number1in,
    input  logic [AW-1:0] number2in,
    output logic [AW-1:0] readadd1,
    output logic [AW-1:0] readadd2,
`ifdef DOUBLE_LOOP_DONE_EN
    output logic          done,
`endif
    output logic          valid
);
    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};
`ifdef DOUBLE_LOOP_DONE_EN
    localparam int PW = 2*AW + 2;
`else
    localparam int PW = 2*AW + 1;
`endif

    logic [AW-1:0] r_n1, r_n2, r_i, r_j, r_a1, r_a2;
    logic          r_active, r_vld;
    logic          w_i_last, w_j_last;
    logic [PW-1:0] w_pipe_in, w_pipe_out;

    // Compare against n-1 so the counters never need to wrap.
    assign w_i_last = (r_i == r_n1 - ONE);
    assign w_j_last = (r_j == r_n2 - ONE);

`ifdef DOUBLE_LOOP_DONE_EN
    logic r_fin, r_done;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_n1     <= number1in;
            r_n2     <= number2in;
            r_i      <= '0;
            r_j      <= '0;
            r_active <= (number1in != '0) && (number2in != '0);
            r_vld    <= 1'b0;
            r_a1     <= '0;
            r_a2     <= '0;
`ifdef DOUBLE_LOOP_DONE_EN
            r_fin    <= (number1in == '0) || (number2in == '0);
            r_done   <= 1'b0;
`endif
        end else begin
`ifdef DOUBLE_LOOP_DONE_EN
            r_done <= r_fin;
            r_fin  <= 1'b0;
`endif
            if (r_active) begin
                r_a1  <= r_i;
                r_a2  <= r_j;
                r_vld <= 1'b1;
                if (w_j_last) begin
                    r_j <= '0;
                    r_i <= r_i + ONE;
                end else begin
                    r_j <= r_j + ONE;
                end
                if (w_i_last && w_j_last) begin
                    r_active <= 1'b0;
`ifdef DOUBLE_LOOP_DONE_EN
                    r_fin    <= 1'b1;
`endif
                end
            end else begin
                r_vld <= 1'b0;
            end
        end
    end

`ifdef DOUBLE_LOOP_DONE_EN
    assign w_pipe_in = {r_vld, r_done, r_a1, r_a2};
    assign {valid, done, readadd1, readadd2} = w_pipe_out;
`else
    assign w_pipe_in = {r_vld, r_a1, r_a2};
    assign {valid, readadd1, readadd2} = w_pipe_out;
`endif

    loop_pipe_delay #(.STAGES(OUT_STAGES), .WIDTH(PW)) u_out_dly (
        .clk   (clk),
        .reset (reset),
        .i_dat (w_pipe_in),
        .o_dat (w_pipe_out)
    );
endmodule

// File: tb/tb_double_loop_gen.sv
// Directed bench for double_loop_gen: an undelayed instance and an OUT_STAGES=3 instance share stimulus.
module tb_double_loop_gen;
    import double_loop_gen_pkg::*;

    logic     clk = 1'b0;
    logic     reset = 1'b0;
    dl_addr_t number1in = '0, number2in = '0;
    dl_addr_t a1_0, a2_0, a1_3, a2_3;
    logic     vld_0, vld_3;
`ifdef DOUBLE_LOOP_DONE_EN
    logic     done_0, done_3;
`endif

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    double_loop_gen #(.AW(DL_AW), .OUT_STAGES(0)) u_dut0 (
        .clk(clk), .reset(reset), .number1in(number1in), .number2in(number2in),
        .readadd1(a1_0), .readadd2(a2_0),
`ifdef DOUBLE_LOOP_DONE_EN
        .done(done_0),
`endif
        .valid(vld_0)
    );

    double_loop_gen #(.AW(DL_AW), .OUT_STAGES(3)) u_dut3 (
        .clk(clk), .reset(reset), .number1in(number1in), .number2in(number2in),
        .readadd1(a1_3), .readadd2(a2_3),
`ifdef DOUBLE_LOOP_DONE_EN
        .done(done_3),
`endif
        .valid(vld_3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Applies a one-cycle reset (edge E0) with the given counts.
    task automatic start(input int n1, input int n2);
        reset     = 1'b1;
        number1in = dl_addr_t'(n1);
        number2in = dl_addr_t'(n2);
        tick();
        reset = 1'b0;
    endtask

    int exp_i1 [6] = '{0, 0, 0, 1, 1, 1};
    int exp_j1 [6] = '{0, 1, 2, 0, 1, 2};
    int exp_i4 [4] = '{0, 0, 0, 1};
    int exp_j4 [4] = '{0, 1, 2, 0};

    initial begin
        int cnt, err, last1, last2, ei, ej, gap;
        bit seen_end;

        // Reset state
        start(0, 0);
        chk("rst_valid", vld_0, 0);
        chk("rst_a1", a1_0, 0);
        chk("rst_a2", a2_0, 0);

        // 2x3 run
        start(2, 3);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("r23_v%0d", k + 1), vld_0, 1);
            chk($sformatf("r23_i%0d", k + 1), a1_0, exp_i1[k]);
            chk($sformatf("r23_j%0d", k + 1), a2_0, exp_j1[k]);
`ifdef DOUBLE_LOOP_DONE_EN
            chk($sformatf("r23_done%0d", k + 1), done_0, 0);
`endif
        end
        tick();
        chk("r23_v7", vld_0, 0);
        chk("r23_hold_i", a1_0, 1);
        chk("r23_hold_j", a2_0, 2);
`ifdef DOUBLE_LOOP_DONE_EN
        chk("r23_done7", done_0, 1);
        tick();
        chk("r23_done8", done_0, 0);
`endif

        // Zero counts: nothing emitted
        start(0, 5);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("z05_v%0d", k), vld_0, 0);
            chk($sformatf("z05_a%0d", k), {a1_0, a2_0}, 0);
`ifdef DOUBLE_LOOP_DONE_EN
            chk($sformatf("z05_done%0d", k), done_0, (k == 1) ? 1 : 0);
`endif
        end
        start(4, 0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("z40_v%0d", k), vld_0, 0);
            chk($sformatf("z40_a%0d", k), {a1_0, a2_0}, 0);
        end

        // Maximum counts
        start(63, 63);
        cnt = 0; err = 0; gap = 0; last1 = -1; last2 = -1; ei = 0; ej = 0;
        seen_end = 1'b0;
        for (int k = 1; k <= 4000; k++) begin
            tick();
            if (vld_0) begin
                if (seen_end || k != cnt + 1) gap++;
                if (int'(a1_0) != ei || int'(a2_0) != ej) err++;
                if (ej == 62) begin ej = 0; ei++; end else ej++;
                cnt++;
                last1 = int'(a1_0);
                last2 = int'(a2_0);
            end else if (cnt > 0) begin
                seen_end = 1'b1;
            end
        end
        chk("max_count", cnt, 3969);
        chk("max_last_i", last1, 62);
        chk("max_last_j", last2, 62);
        chk("max_order_err", err, 0);
        chk("max_gaps", gap, 0);

        // Restart mid-run
        start(3, 3);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr_v%0d", k + 1), vld_0, 1);
            chk($sformatf("rr_pair%0d", k + 1), {a1_0, a2_0}, {dl_addr_t'(exp_i4[k]), dl_addr_t'(exp_j4[k])});
        end
        start(1, 2);
        chk("rr_v5", vld_0, 0);
        tick();
        chk("rr_v6", vld_0, 1);
        chk("rr_pair6", {a1_0, a2_0}, {6'd0, 6'd0});
        tick();
        chk("rr_v7", vld_0, 1);
        chk("rr_pair7", {a1_0, a2_0}, {6'd0, 6'd1});
        tick();
        chk("rr_v8", vld_0, 0);

        // Counts changed after the reset cycle are ignored
        start(1, 1);
        tick();
        chk("ign_v1", vld_0, 1);
        chk("ign_pair1", {a1_0, a2_0}, 0);
        number1in = 6'd7;
        number2in = 6'd7;
        for (int k = 2; k <= 6; k++) begin
            tick();
            chk($sformatf("ign_v%0d", k), vld_0, 0);
        end

        // Output delay of 3 stages
        start(1, 2);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("d3_v%0d", k), vld_3, (k == 4 || k == 5) ? 1 : 0);
            chk($sformatf("d0_v%0d", k), vld_0, (k == 1 || k == 2) ? 1 : 0);
            if (k == 4) chk("d3_pair4", {a1_3, a2_3}, {6'd0, 6'd0});
            if (k == 5) chk("d3_pair5", {a1_3, a2_3}, {6'd0, 6'd1});
`ifdef DOUBLE_LOOP_DONE_EN
            chk($sformatf("d3_done%0d", k), done_3, (k == 6) ? 1 : 0);
            chk($sformatf("d0_done%0d", k), done_0, (k == 3) ? 1 : 0);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
